// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Raster timing bundle from the VGA timing generator to renderers.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if;
   logic       pixel_tick;
   logic [9:0] Q_X;
   logic [9:0] Q_Y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       line_start;
   logic       frame_start;

   modport master (
      output pixel_tick, Q_X, Q_Y, hsync, vsync, video_on, line_start, frame_start
   );

   modport slave (
      input  pixel_tick, Q_X, Q_Y, hsync, vsync, video_on, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing: pixel divider, H/V counters, syncs, blanking.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 2
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   vga_timing_gen_if.master   vga
);

   localparam int unsigned c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
   localparam logic [9:0]         c_h_max   = 10'(c_h_total - 1);
   localparam logic [9:0]         c_v_max   = 10'(c_v_total - 1);

   // Decode bounds carry an 11th bit so a sync ending exactly at 1024 still compares correctly.
   localparam logic [10:0] c_h_vis   = 11'(H_VISIBLE);
   localparam logic [10:0] c_hs_lo   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] c_hs_hi   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] c_v_vis   = 11'(V_VISIBLE);
   localparam logic [10:0] c_vs_lo   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] c_vs_hi   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   generate
      if (c_h_total > 1024) begin : g_bad_h_total
         $error("vga_timing_gen: H_TOTAL exceeds 1024");
      end
      if (c_v_total > 1024) begin : g_bad_v_total
         $error("vga_timing_gen: V_TOTAL exceeds 1024");
      end
      if (CLK_DIV < 1) begin : g_bad_clk_div
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
   logic               pixel_tick_q, pixel_tick_d;
   logic [9:0]         x_q, x_d;
   logic [9:0]         y_q, y_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   logic [10:0]        x_ext;
   logic [10:0]        y_ext;

   always_comb begin
      div_cnt_d     = (div_cnt_q == c_div_max) ? '0 : div_cnt_q + c_div_w'(1);
      pixel_tick_d  = (div_cnt_q == c_div_max);

      x_d           = x_q;
      y_d           = y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      x_ext         = '0;
      y_ext         = '0;

      if (pixel_tick_q) begin
         if (x_q == c_h_max) begin
            x_d          = '0;
            line_start_d = 1'b1;
            if (y_q == c_v_max) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end

         // Decode the position being loaded so syncs/blanking never lag Q_X/Q_Y.
         x_ext      = {1'b0, x_d};
         y_ext      = {1'b0, y_d};
         hsync_d    = !((x_ext >= c_hs_lo) && (x_ext < c_hs_hi));
         vsync_d    = !((y_ext >= c_vs_lo) && (y_ext < c_vs_hi));
         video_on_d = (x_ext < c_h_vis) && (y_ext < c_v_vis);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         pixel_tick_q  <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pixel_tick_q  <= pixel_tick_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.pixel_tick  = pixel_tick_q;
   assign vga.Q_X         = x_q;
   assign vga.Q_Y         = y_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for three timing configurations of vga_timing_gen.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

   logic clk;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_edge = 0;

   logic [25:0] q0[$];
   logic [25:0] q1[$];
   logic [25:0] q2[$];

   localparam logic [25:0] c_rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000};

   vga_timing_gen_if if_a();
   vga_timing_gen_if if_b();
   vga_timing_gen_if if_c();

   vga_timing_gen #(
      .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2),  .V_BACK(33), .CLK_DIV(2)
   ) u_a (.clk(clk), .rst_n(rst_n), .vga(if_a));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
   ) u_b (.clk(clk), .rst_n(rst_n), .vga(if_b));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(3)
   ) u_c (.clk(clk), .rst_n(rst_n), .vga(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: everything follows from n = clk edges since reset release.
   // Ticks seen before edge n = floor((n-1)/D); that count is the linear pixel index.
   function automatic logic [25:0] model(input int n, input int dv,
                                         input int hv, input int hf, input int hsw, input int hb,
                                         input int vv, input int vf, input int vsw, input int vb);
      int ht, vt, p, pp, x, y;
      logic tk, hs, vs, von, ls, fs;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      if (n == 0) return c_rst_vec;
      tk  = (n % dv) == 0;
      p   = (n - 1) / dv;
      pp  = (n >= 2) ? (n - 2) / dv : 0;
      x   = p % ht;
      y   = (p / ht) % vt;
      hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
      vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
      von = (p > 0) && (x < hv) && (y < vv);
      ls  = (p != pp) && (x == 0);
      fs  = ls && (y == 0);
      return {tk, 10'(x), 10'(y), hs, vs, von, ls, fs};
   endfunction

   function automatic logic [25:0] model_d(input int d, input int n);
      case (d)
         0:       return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
         1:       return model(n, 1, 8, 2, 3, 2, 4, 1, 1, 1);
         default: return model(n, 3, 8, 2, 3, 2, 4, 1, 1, 1);
      endcase
   endfunction

   function automatic logic [25:0] act_vec(input int d);
      case (d)
         0: return {if_a.pixel_tick, if_a.Q_X, if_a.Q_Y, if_a.hsync, if_a.vsync,
                    if_a.video_on, if_a.line_start, if_a.frame_start};
         1: return {if_b.pixel_tick, if_b.Q_X, if_b.Q_Y, if_b.hsync, if_b.vsync,
                    if_b.video_on, if_b.line_start, if_b.frame_start};
         default: return {if_c.pixel_tick, if_c.Q_X, if_c.Q_Y, if_c.hsync, if_c.vsync,
                          if_c.video_on, if_c.line_start, if_c.frame_start};
      endcase
   endfunction

   function automatic int div_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
   endfunction

   task automatic chk(input string name, input int d, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut=%0d t=%0t: got %0d (0x%0h) want %0d (0x%0h)",
                  name, d, $time, act, act, exp, exp);
      end
   endtask

   // Stimulus side of the scoreboard: push the expected state for each edge.
   always @(posedge clk) begin
      int nn;
      nn = rst_n ? n_edge + 1 : 0;
      n_edge <= nn;
      q0.push_back(model_d(0, nn));
      q1.push_back(model_d(1, nn));
      q2.push_back(model_d(2, nn));
   end

   // Monitor side: compare what the DUTs present mid-cycle.
   always @(negedge clk) begin
      if (q0.size() > 0) chk("cycle", 0, int'(act_vec(0)), int'(q0.pop_front()));
      if (q1.size() > 0) chk("cycle", 1, int'(act_vec(1)), int'(q1.pop_front()));
      if (q2.size() > 0) chk("cycle", 2, int'(act_vec(2)), int'(q2.pop_front()));
   end

   task automatic check_reset_now(input string name);
      for (int d = 0; d < 3; d++) chk(name, d, int'(act_vec(d)), int'(c_rst_vec));
   endtask

   // Release at a falling edge, then verify first-tick latency and that Q_X reaches 1.
   task automatic release_and_check_latency();
      int first_tick[3];
      int x_after[3];
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         first_tick[d] = 0;
         x_after[d]    = -1;
      end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            logic [25:0] v;
            v = act_vec(d);
            if (first_tick[d] == 0 && v[25]) first_tick[d] = c;
            if (c == div_of(d) + 1) x_after[d] = int'(v[24:15]);
         end
      end
      for (int d = 0; d < 3; d++) begin
         chk("first_tick_latency", d, first_tick[d], div_of(d));
         chk("x_after_first_tick", d, x_after[d], 1);
      end
   endtask

   // Assert reset between clock edges and confirm outputs fall back without a clock.
   task automatic async_reset(input int hold);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_reset_now("async_rst");
      repeat (hold) @(negedge clk);
      check_reset_now("rst_hold");
   endtask

   // Measure one interval between consecutive line_start (use_fs=0) or frame_start pulses.
   task automatic measure(input int d, input bit use_fs, input int bound,
                          output int period, output int hs_lo, output int vs_lo,
                          output int von_n, output int ls_n, output bit ok);
      logic [25:0] v;
      int k;
      period = 0; hs_lo = 0; vs_lo = 0; von_n = 0; ls_n = 0; ok = 1'b0;
      k = 0;
      v = act_vec(d);
      while (!(use_fs ? v[0] : v[1]) && k < bound) begin
         @(negedge clk);
         v = act_vec(d);
         k++;
      end
      if (!(use_fs ? v[0] : v[1])) return;
      do begin
         if (!v[4]) hs_lo++;
         if (!v[3]) vs_lo++;
         if (v[2])  von_n++;
         if (v[1])  ls_n++;
         period++;
         @(negedge clk);
         v = act_vec(d);
      end while (!(use_fs ? v[0] : v[1]) && period < bound);
      ok = use_fs ? v[0] : v[1];
   endtask

   task automatic check_frame(input int d, input int exp_period, input int exp_hs,
                              input int exp_vs, input int exp_von);
      int per, hs, vs, von, ls;
      bit ok;
      measure(d, 1'b1, 4 * exp_period, per, hs, vs, von, ls, ok);
      chk("frame_found", d, int'(ok), 1);
      chk("frame_period", d, per, exp_period);
      chk("frame_hsync_low", d, hs, exp_hs);
      chk("frame_vsync_low", d, vs, exp_vs);
      chk("frame_video_on", d, von, exp_von);
      chk("frame_line_starts", d, ls, 7);
   endtask

   initial begin
      int per, hs, vs, von, ls, k;
      bit ok;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_now("rst_hold");
      release_and_check_latency();

      check_frame(1, 105, 21, 15, 32);
      check_frame(2, 315, 63, 45, 96);

      measure(0, 1'b0, 4000, per, hs, vs, von, ls, ok);
      chk("line_found", 0, int'(ok), 1);
      chk("line_period", 0, per, 1600);
      chk("line_hsync_low", 0, hs, 192);
      chk("line_video_on", 0, von, 1280);
      chk("line_vsync_low", 0, vs, 0);

      // Reset while the small-config DUT sits inside both sync pulses.
      k = 0;
      while (!(if_b.hsync == 1'b0 && if_b.vsync == 1'b0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("reach_in_sync", 1, int'(!if_b.hsync && !if_b.vsync), 1);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_reset_now("async_rst_in_sync");
      repeat ($urandom_range(1, 5)) @(negedge clk);
      release_and_check_latency();
      check_frame(1, 105, 21, 15, 32);

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(20, 600)) @(negedge clk);
         async_reset($urandom_range(1, 6));
         release_and_check_latency();
      end

      check_frame(2, 315, 63, 45, 96);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
